// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes and the arbiter state encoding.
package axi_lite_pkg;

    // AXI response codes carried on RRESP / BRESP
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    // Arbiter top-level state: idle, serving a read, serving a write
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } arb_state_t;

    // Index that follows idx in round-robin order, wrapping at n-1 -> 0
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans requests starting at the pointer,
// wrapping at N-1 -> 0, and returns the first requester as one-hot and index.
module rr_arbiter #(
    parameter int N = 2,
    localparam int GW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [GW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [GW-1:0] o_grant_idx,
    output logic          o_valid
);

    int   w_idx;
    logic w_found;

    // Walk the N candidates in priority order beginning at the pointer
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_valid     = 1'b0;
        w_found     = 1'b0;
        w_idx       = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!w_found && (w_idx < N) && i_req[w_idx]) begin
                w_found          = 1'b1;
                o_grant[w_idx]   = 1'b1;
                o_grant_idx      = GW'(w_idx);
            end
        end
        o_valid = w_found;
    end

endmodule

// File: rtl/axi_lite_arbiter.sv
// N-master to 1-slave AXI-Lite arbiter. One transaction in flight, round-robin
// fairness, responses routed back to the master that owns the grant.
//
// Handshake rule used on every channel: a beat transfers on the rising clock
// edge where VALID and READY are both high; a source keeps VALID and payload
// stable until that edge, and READY may depend combinationally on VALID.
module axi_lite_arbiter
    import axi_lite_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    localparam int GW         = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    localparam int SW         = DATA_W / 8
) (
    input  logic                          clock,
    input  logic                          reset,

    // Upstream masters, master i in slice [i*W +: W]
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_araddr,
    input  logic [NUM_MASTERS-1:0]        m_arvalid,
    output logic [NUM_MASTERS-1:0]        m_arready,
    output logic [NUM_MASTERS*DATA_W-1:0] m_rdata,
    output logic [NUM_MASTERS*2-1:0]      m_rresp,
    output logic [NUM_MASTERS-1:0]        m_rvalid,
    input  logic [NUM_MASTERS-1:0]        m_rready,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_awaddr,
    input  logic [NUM_MASTERS-1:0]        m_awvalid,
    output logic [NUM_MASTERS-1:0]        m_awready,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
    input  logic [NUM_MASTERS*SW-1:0]     m_wstrb,
    input  logic [NUM_MASTERS-1:0]        m_wvalid,
    output logic [NUM_MASTERS-1:0]        m_wready,
    output logic [NUM_MASTERS*2-1:0]      m_bresp,
    output logic [NUM_MASTERS-1:0]        m_bvalid,
    input  logic [NUM_MASTERS-1:0]        m_bready,

    // Downstream slave
    output logic [ADDR_W-1:0]             s_araddr,
    output logic                          s_arvalid,
    input  logic                          s_arready,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic [1:0]                    s_rresp,
    input  logic                          s_rvalid,
    output logic                          s_rready,
    output logic [ADDR_W-1:0]             s_awaddr,
    output logic                          s_awvalid,
    input  logic                          s_awready,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [SW-1:0]                 s_wstrb,
    output logic                          s_wvalid,
    input  logic                          s_wready,
    input  logic [1:0]                    s_bresp,
    input  logic                          s_bvalid,
    output logic                          s_bready,

    // Observation of internal arbitration state
    output arb_state_t                    o_dbg_state,
    output logic [GW-1:0]                 o_dbg_grant,
    output logic [GW-1:0]                 o_dbg_ptr
);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    arb_state_t r_state;
    arb_state_t w_next_state;
    logic [GW-1:0] r_grant;
    logic [GW-1:0] r_ptr;
    logic          r_ar_done;
    logic          r_aw_done;
    logic          r_w_done;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NUM_MASTERS-1:0] w_req;
    logic [NUM_MASTERS-1:0] w_win_oh;
    logic [GW-1:0]          w_win_idx;
    logic                   w_win_valid;
    logic                   w_win_rd;
    logic [GW-1:0]          w_next_ptr;

    assign w_req = m_arvalid | m_awvalid;

    rr_arbiter #(
        .N (NUM_MASTERS)
    ) u_rr (
        .i_req       (w_req),
        .i_ptr       (r_ptr),
        .o_grant     (w_win_oh),
        .o_grant_idx (w_win_idx),
        .o_valid     (w_win_valid)
    );

    // A master asking for both read and write is served the read first
    assign w_win_rd   = |(w_win_oh & m_arvalid);
    assign w_next_ptr = GW'(rr_next(int'(r_grant), NUM_MASTERS));

    // ------------------------------------------------------------------
    // Granted master's inputs and channel handshakes
    // ------------------------------------------------------------------
    logic w_g_arvalid;
    logic w_g_rready;
    logic w_g_awvalid;
    logic w_g_wvalid;
    logic w_g_bready;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_wr_both;

    assign w_g_arvalid = m_arvalid[r_grant];
    assign w_g_rready  = m_rready[r_grant];
    assign w_g_awvalid = m_awvalid[r_grant];
    assign w_g_wvalid  = m_wvalid[r_grant];
    assign w_g_bready  = m_bready[r_grant];

    assign w_ar_hs   = s_arvalid & s_arready;
    assign w_r_hs    = s_rvalid  & s_rready;
    assign w_aw_hs   = s_awvalid & s_awready;
    assign w_w_hs    = s_wvalid  & s_wready;
    assign w_b_hs    = s_bvalid  & s_bready;
    assign w_wr_both = r_aw_done & r_w_done;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: leave IDLE on any request, return after the response beat
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_win_valid) begin
                    w_next_state = w_win_rd ? RD : WR;
                end
            end
            RD: begin
                if (w_r_hs) begin
                    w_next_state = IDLE;
                end
            end
            WR: begin
                if (w_b_hs) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Grant, pointer and per-channel completion flags
    always_ff @(posedge clock) begin
        if (reset) begin
            r_grant   <= '0;
            r_ptr     <= '0;
            r_ar_done <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_win_valid) begin
                        r_grant <= w_win_idx;
                    end
                end
                RD: begin
                    if (w_ar_hs) begin
                        r_ar_done <= 1'b1;
                    end
                    if (w_r_hs) begin
                        r_ar_done <= 1'b0;
                        r_ptr     <= w_next_ptr;
                    end
                end
                WR: begin
                    if (w_aw_hs) begin
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_w_done <= 1'b1;
                    end
                    if (w_b_hs) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_ptr     <= w_next_ptr;
                    end
                end
                default: begin
                    r_ar_done <= 1'b0;
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Payload muxes (selected by the registered grant) and broadcasts
    // ------------------------------------------------------------------
    assign s_araddr = m_araddr[int'(r_grant)*ADDR_W +: ADDR_W];
    assign s_awaddr = m_awaddr[int'(r_grant)*ADDR_W +: ADDR_W];
    assign s_wdata  = m_wdata[int'(r_grant)*DATA_W +: DATA_W];
    assign s_wstrb  = m_wstrb[int'(r_grant)*SW +: SW];

    // Response payloads go to every master; only the granted one sees valid
    assign m_rdata = {NUM_MASTERS{s_rdata}};
    assign m_rresp = {NUM_MASTERS{s_rresp}};
    assign m_bresp = {NUM_MASTERS{s_bresp}};

    // ------------------------------------------------------------------
    // Channel valid/ready routing
    // ------------------------------------------------------------------

    // Read address and read data: forwarded only while serving a read
    always_comb begin
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        m_arready = '0;
        m_rvalid  = '0;
        if (r_state == RD) begin
            s_arvalid          = !r_ar_done & w_g_arvalid;
            m_arready[r_grant] = !r_ar_done & s_arready;
            s_rready           = w_g_rready;
            m_rvalid[r_grant]  = s_rvalid;
        end
    end

    // Write address and write data: independent, each masked once accepted
    always_comb begin
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        m_awready = '0;
        m_wready  = '0;
        if (r_state == WR) begin
            s_awvalid          = !r_aw_done & w_g_awvalid;
            m_awready[r_grant] = !r_aw_done & s_awready;
            s_wvalid           = !r_w_done & w_g_wvalid;
            m_wready[r_grant]  = !r_w_done & s_wready;
        end
    end

    // Write response: only accepted once both AW and W have transferred
    always_comb begin
        s_bready = 1'b0;
        m_bvalid = '0;
        if ((r_state == WR) && w_wr_both) begin
            s_bready          = w_g_bready;
            m_bvalid[r_grant] = s_bvalid;
        end
    end

    // ------------------------------------------------------------------
    // Debug view
    // ------------------------------------------------------------------
    assign o_dbg_state = r_state;
    assign o_dbg_grant = r_grant;
    assign o_dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter with two masters and a simple slave model.
module tb_axi_lite_arbiter;
  import axi_lite_pkg::*;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam logic [31:0] RD_XOR = 32'h5EAD_BEEF;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic [N*AW-1:0] m_araddr = '0, m_awaddr = '0;
  logic [N-1:0]    m_arvalid = '0, m_awvalid = '0, m_wvalid = '0;
  logic [N-1:0]    m_rready = '1, m_bready = '1;
  logic [N*DW-1:0] m_wdata = '0;
  logic [N*SW-1:0] m_wstrb = '0;
  logic [N-1:0]    m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
  logic [N*DW-1:0] m_rdata;
  logic [N*2-1:0]  m_rresp, m_bresp;

  logic [AW-1:0] s_araddr, s_awaddr;
  logic          s_arvalid, s_arready, s_rready, s_awvalid, s_awready;
  logic          s_wvalid, s_wready, s_bready;
  logic [DW-1:0] s_wdata;
  logic [SW-1:0] s_wstrb;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp, s_bresp;
  logic          s_rvalid, s_bvalid;

  arb_state_t dbg_state;
  logic [0:0] dbg_grant, dbg_ptr;

  axi_lite_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .o_dbg_state(dbg_state), .o_dbg_grant(dbg_grant), .o_dbg_ptr(dbg_ptr)
  );

  // ---------------- slave model ----------------
  // Always ready; read data = addr ^ RD_XOR, resp = SLVERR when addr[4] set.
  logic        sl_ready = 1'b1;
  logic [31:0] sl_awaddr, sl_wdata;
  logic [3:0]  sl_wstrb;
  logic        sl_got_aw, sl_got_w;
  int          sl_ar_cnt = 0, sl_aw_cnt = 0, sl_w_cnt = 0;

  assign s_arready = sl_ready;
  assign s_awready = sl_ready;
  assign s_wready  = sl_ready;

  always @(posedge clock) begin
    if (reset) begin
      s_rvalid  <= 1'b0;
      s_bvalid  <= 1'b0;
      sl_got_aw <= 1'b0;
      sl_got_w  <= 1'b0;
    end else begin
      if (s_arvalid && s_arready) begin
        sl_ar_cnt <= sl_ar_cnt + 1;
        s_rvalid  <= 1'b1;
        s_rdata   <= s_araddr ^ RD_XOR;
        s_rresp   <= s_araddr[4] ? SLVERR : OKAY;
      end else if (s_rvalid && s_rready) begin
        s_rvalid <= 1'b0;
      end
      if (s_awvalid && s_awready) begin
        sl_aw_cnt <= sl_aw_cnt + 1;
        sl_got_aw <= 1'b1;
        sl_awaddr <= s_awaddr;
      end
      if (s_wvalid && s_wready) begin
        sl_w_cnt <= sl_w_cnt + 1;
        sl_got_w <= 1'b1;
        sl_wdata <= s_wdata;
        sl_wstrb <= s_wstrb;
      end
      if (s_bvalid && s_bready) begin
        s_bvalid  <= 1'b0;
        sl_got_aw <= 1'b0;
        sl_got_w  <= 1'b0;
      end else if (sl_got_aw && sl_got_w && !s_bvalid) begin
        s_bvalid <= 1'b1;
        s_bresp  <= sl_awaddr[4] ? SLVERR : OKAY;
      end
    end
  end

  // ---------------- scoreboard state ----------------
  int          tests_run = 0;
  int          tests_failed = 0;
  int          rd_cnt[N];
  int          wr_cnt[N];
  logic [31:0] rd_data[N];
  logic [1:0]  rd_resp[N];
  logic [1:0]  wr_resp[N];
  logic [31:0] ar_log[$];
  logic [31:0] exp_q[$];
  logic [N-1:0] ar_hs, aw_hs, w_hs, r_hs, b_hs;

  // ---------------- driver tasks ----------------
  // One clock: sample handshakes before the edge, retire accepted beats after it.
  task automatic tick();
    @(negedge clock);
    ar_hs = m_arvalid & m_arready;
    aw_hs = m_awvalid & m_awready;
    w_hs  = m_wvalid & m_wready;
    r_hs  = m_rvalid & m_rready;
    b_hs  = m_bvalid & m_bready;
    for (int i = 0; i < N; i++) begin
      if (r_hs[i]) begin
        rd_cnt[i]++;
        rd_data[i] = m_rdata[i*DW +: DW];
        rd_resp[i] = m_rresp[i*2 +: 2];
      end
      if (b_hs[i]) begin
        wr_cnt[i]++;
        wr_resp[i] = m_bresp[i*2 +: 2];
      end
    end
    if (s_arvalid && s_arready) ar_log.push_back(s_araddr);
    @(posedge clock);
    #1;
    m_arvalid = m_arvalid & ~ar_hs;
    m_awvalid = m_awvalid & ~aw_hs;
    m_wvalid  = m_wvalid & ~w_hs;
  endtask

  // Issue one read from master m and wait (bounded) for its response.
  task automatic do_read(input int m, input logic [31:0] addr, output bit ok);
    int base;
    base = rd_cnt[m];
    m_araddr[m*AW +: AW] = addr;
    m_arvalid[m] = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 30 && !ok; c++) begin
      tick();
      if (rd_cnt[m] != base) ok = 1'b1;
    end
  endtask

  function automatic logic [14:0] ctl_outs();
    return {m_arready, m_rvalid, m_awready, m_wready, m_bvalid,
            s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    m_arvalid = 2'b11;
    m_awvalid = 2'b11;
    repeat (3) tick();
    tests_run++;
    if (ctl_outs() !== 15'd0) begin
      tests_failed++; $display("FAIL reset_outs_in_reset: got %b expected 0", ctl_outs());
    end
    m_arvalid = '0;
    m_awvalid = '0;
    reset = 1'b0;
    #1;
    tests_run++;
    if (dbg_state !== IDLE) begin
      tests_failed++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    end
    tests_run++;
    if ({dbg_ptr, dbg_grant} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_ptr_grant: got %b expected 00", {dbg_ptr, dbg_grant});
    end
    tests_run++;
    if (ctl_outs() !== 15'd0) begin
      tests_failed++; $display("FAIL reset_outs: got %b expected 0", ctl_outs());
    end
  endtask

  task automatic test_single_read();
    m_araddr[31:0] = 32'h8000_0000;
    m_arvalid = 2'b01;
    #1;
    tests_run++;
    if (s_arvalid !== 1'b0) begin
      tests_failed++; $display("FAIL single_idle_no_fwd: got %b expected 0", s_arvalid);
    end
    tick();
    tests_run++;
    if ({dbg_state, dbg_grant, s_arvalid, m_arready} !== {RD, 1'b0, 1'b1, 2'b01}) begin
      tests_failed++; $display("FAIL single_grant: got %b expected %b",
        {dbg_state, dbg_grant, s_arvalid, m_arready}, {RD, 1'b0, 1'b1, 2'b01});
    end
    tests_run++;
    if (s_araddr !== 32'h8000_0000) begin
      tests_failed++; $display("FAIL single_araddr: got %h expected 80000000", s_araddr);
    end
    tick();
    tests_run++;
    if ({s_arvalid, m_rvalid} !== 3'b001) begin
      tests_failed++; $display("FAIL single_rvalid: got %b expected 001", {s_arvalid, m_rvalid});
    end
    tests_run++;
    if ({m_rdata[31:0], m_rresp[1:0]} !== {32'hDEAD_BEEF, OKAY}) begin
      tests_failed++; $display("FAIL single_rdata: got %h/%b expected deadbeef/00", m_rdata[31:0], m_rresp[1:0]);
    end
    tick();
    tests_run++;
    if ({dbg_state, dbg_ptr, m_rvalid} !== {IDLE, 1'b1, 2'b00}) begin
      tests_failed++; $display("FAIL single_done: got %b expected %b", {dbg_state, dbg_ptr, m_rvalid}, {IDLE, 1'b1, 2'b00});
    end
    tests_run++;
    if (rd_cnt[0] !== 1 || rd_cnt[1] !== 0 || rd_data[0] !== 32'hDEAD_BEEF) begin
      tests_failed++; $display("FAIL single_routed: got cnt %0d/%0d data %h expected 1/0 deadbeef",
        rd_cnt[0], rd_cnt[1], rd_data[0]);
    end
  endtask

  task automatic test_contention();
    int base[N];
    int issued[N];
    bit done;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ar_log.delete();
    exp_q = '{32'h0000_1000, 32'h0000_2010, 32'h0000_1100, 32'h0000_2110};
    for (int i = 0; i < N; i++) base[i] = rd_cnt[i];
    m_araddr[31:0]  = 32'h0000_1000;
    m_araddr[63:32] = 32'h0000_2010;
    m_arvalid = 2'b11;
    issued[0] = 1;
    issued[1] = 1;
    done = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!m_arvalid[i] && (rd_cnt[i] - base[i]) == issued[i] && issued[i] < 2) begin
          m_araddr[i*AW +: AW] = (i == 0) ? 32'h0000_1100 : 32'h0000_2110;
          m_arvalid[i] = 1'b1;
          issued[i]++;
        end
      end
      done = (rd_cnt[0] - base[0] == 2) && (rd_cnt[1] - base[1] == 2);
    end
    tests_run++;
    if (!done) begin
      tests_failed++; $display("FAIL contention_timeout: got %0d/%0d reads expected 2/2",
        rd_cnt[0] - base[0], rd_cnt[1] - base[1]);
    end
    tests_run++;
    if (ar_log.size() !== 4) begin
      tests_failed++; $display("FAIL contention_ar_count: got %0d expected 4", ar_log.size());
    end
    for (int k = 0; k < 4; k++) begin
      logic [31:0] got;
      got = (ar_log.size() > 0) ? ar_log.pop_front() : 32'hxxxx_xxxx;
      tests_run++;
      if (got !== exp_q[k]) begin
        tests_failed++; $display("FAIL contention_order[%0d]: got %h expected %h", k, got, exp_q[k]);
      end
    end
    tests_run++;
    if (rd_data[0] !== (32'h0000_1100 ^ RD_XOR) || rd_data[1] !== (32'h0000_2110 ^ RD_XOR)) begin
      tests_failed++; $display("FAIL contention_data: got %h/%h expected %h/%h",
        rd_data[0], rd_data[1], 32'h0000_1100 ^ RD_XOR, 32'h0000_2110 ^ RD_XOR);
    end
    tests_run++;
    if ({rd_resp[0], rd_resp[1]} !== {OKAY, SLVERR}) begin
      tests_failed++; $display("FAIL contention_resp: got %b expected 0010", {rd_resp[0], rd_resp[1]});
    end
  endtask

  task automatic test_write_skew();
    int aw0, w0, b0, b1;
    logic leak;
    bit ok;
    aw0 = sl_aw_cnt; w0 = sl_w_cnt; b0 = wr_cnt[0]; b1 = wr_cnt[1];
    m_wdata[63:32] = 32'hCAFE_0001;
    m_wstrb[7:4]   = 4'h3;
    m_wvalid       = 2'b10;
    leak = 1'b0;
    repeat (3) begin
      tick();
      leak = leak | s_wvalid | (|m_wready) | (dbg_state != IDLE);
    end
    tests_run++;
    if (leak !== 1'b0) begin
      tests_failed++; $display("FAIL skew_w_without_aw: got %b expected 0", leak);
    end
    m_awaddr[63:32] = 32'h0000_3000;
    m_awvalid = 2'b10;
    tick();
    tests_run++;
    if ({dbg_state, dbg_grant} !== {WR, 1'b1}) begin
      tests_failed++; $display("FAIL skew_grant: got %b expected %b", {dbg_state, dbg_grant}, {WR, 1'b1});
    end
    ok = 1'b0;
    leak = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      tick();
      leak = leak | m_bvalid[0];
      if (wr_cnt[1] != b1) ok = 1'b1;
    end
    tests_run++;
    if (!ok || leak) begin
      tests_failed++; $display("FAIL skew_b_route: got done %b m0_b %b expected 1 0", ok, leak);
    end
    tests_run++;
    if ({sl_aw_cnt - aw0, sl_w_cnt - w0} !== {32'd1, 32'd1}) begin
      tests_failed++; $display("FAIL skew_beats: got aw %0d w %0d expected 1 1", sl_aw_cnt - aw0, sl_w_cnt - w0);
    end
    tests_run++;
    if ({sl_awaddr, sl_wdata, sl_wstrb} !== {32'h0000_3000, 32'hCAFE_0001, 4'h3}) begin
      tests_failed++; $display("FAIL skew_payload: got %h %h %h expected 00003000 cafe0001 3",
        sl_awaddr, sl_wdata, sl_wstrb);
    end
    tests_run++;
    if (wr_resp[1] !== OKAY || wr_cnt[0] !== b0) begin
      tests_failed++; $display("FAIL skew_bresp: got %b cnt0 %0d expected 00 %0d", wr_resp[1], wr_cnt[0], b0);
    end
    // AW first, W two cycles later, from master 0
    m_awaddr[31:0] = 32'h0000_3040;
    m_awvalid = 2'b01;
    tick();
    tick();
    tests_run++;
    if ({dbg_state, dbg_grant, s_awvalid, m_bvalid} !== {WR, 1'b0, 1'b0, 2'b00}) begin
      tests_failed++; $display("FAIL skew2_wait_w: got %b expected %b",
        {dbg_state, dbg_grant, s_awvalid, m_bvalid}, {WR, 1'b0, 1'b0, 2'b00});
    end
    tick();
    m_wdata[31:0] = 32'h0BAD_F00D;
    m_wstrb[3:0]  = 4'hC;
    m_wvalid      = 2'b01;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      tick();
      if (wr_cnt[0] != b0) ok = 1'b1;
    end
    tests_run++;
    if (!ok || {sl_aw_cnt - aw0, sl_w_cnt - w0} !== {32'd2, 32'd2}
        || {sl_wdata, sl_wstrb} !== {32'h0BAD_F00D, 4'hC}) begin
      tests_failed++; $display("FAIL skew2_done: got ok %b aw %0d w %0d %h %h expected 1 2 2 0badf00d c",
        ok, sl_aw_cnt - aw0, sl_w_cnt - w0, sl_wdata, sl_wstrb);
    end
  endtask

  task automatic test_rd_wr_same();
    int b0, b1;
    bit ok;
    b0 = wr_cnt[0]; b1 = wr_cnt[1];
    m_araddr[31:0] = 32'h0000_6000;
    m_awaddr[31:0] = 32'h0000_6010;
    m_wdata[31:0]  = 32'h1234_5678;
    m_wstrb[3:0]   = 4'hF;
    m_arvalid = 2'b01;
    m_awvalid = 2'b01;
    m_wvalid  = 2'b01;
    tick();
    tests_run++;
    if ({dbg_state, dbg_grant, s_awvalid, s_wvalid} !== {RD, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++; $display("FAIL rdwr_read_first: got %b expected %b",
        {dbg_state, dbg_grant, s_awvalid, s_wvalid}, {RD, 1'b0, 1'b0, 1'b0});
    end
    tick();
    tick();
    tests_run++;
    if (dbg_state !== IDLE || rd_data[0] !== (32'h0000_6000 ^ RD_XOR)) begin
      tests_failed++; $display("FAIL rdwr_read_done: got %0d %h expected %0d %h",
        dbg_state, rd_data[0], IDLE, 32'h0000_6000 ^ RD_XOR);
    end
    tick();
    tests_run++;
    if ({dbg_state, dbg_grant} !== {WR, 1'b0}) begin
      tests_failed++; $display("FAIL rdwr_write_next: got %b expected %b", {dbg_state, dbg_grant}, {WR, 1'b0});
    end
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      tick();
      if (wr_cnt[0] != b0) ok = 1'b1;
    end
    tests_run++;
    if (!ok || wr_resp[0] !== SLVERR || wr_cnt[1] !== b1 || sl_awaddr !== 32'h0000_6010) begin
      tests_failed++; $display("FAIL rdwr_write_done: got ok %b resp %b cnt1 %0d addr %h expected 1 10 %0d 00006010",
        ok, wr_resp[0], wr_cnt[1], sl_awaddr, b1);
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] exp_v;
    bit ok;
    m_rready = 2'b10;
    m_araddr[31:0] = 32'h0000_4000;
    m_arvalid = 2'b01;
    tick();
    tick();
    m_araddr[63:32] = 32'h0000_4400;
    m_arvalid[1] = 1'b1;
    exp_v = {1'b1, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0, RD, 2'b00};
    for (int c = 0; c < 5; c++) begin
      tick();
      tests_run++;
      if ({s_rvalid, s_rready, m_rvalid, dbg_grant, m_arready, s_arvalid, dbg_state, m_bvalid} !== exp_v) begin
        tests_failed++; $display("FAIL bp_hold[%0d]: got %b expected %b", c,
          {s_rvalid, s_rready, m_rvalid, dbg_grant, m_arready, s_arvalid, dbg_state, m_bvalid}, exp_v);
      end
      tests_run++;
      if (m_rdata[31:0] !== (32'h0000_4000 ^ RD_XOR)) begin
        tests_failed++; $display("FAIL bp_data[%0d]: got %h expected %h", c, m_rdata[31:0], 32'h0000_4000 ^ RD_XOR);
      end
    end
    m_rready = 2'b11;
    do_read(1, 32'h0000_4400, ok);
    tests_run++;
    if (!ok || rd_data[0] !== (32'h0000_4000 ^ RD_XOR) || rd_data[1] !== (32'h0000_4400 ^ RD_XOR)) begin
      tests_failed++; $display("FAIL bp_release: got ok %b %h %h expected 1 %h %h", ok,
        rd_data[0], rd_data[1], 32'h0000_4000 ^ RD_XOR, 32'h0000_4400 ^ RD_XOR);
    end
  endtask

  task automatic test_mid_reset();
    int r1;
    bit ok;
    do_read(0, 32'h0000_5000, ok);
    tests_run++;
    if (!ok || dbg_ptr !== 1'b1) begin
      tests_failed++; $display("FAIL midrst_setup: got ok %b ptr %b expected 1 1", ok, dbg_ptr);
    end
    m_rready = 2'b00;
    r1 = rd_cnt[1];
    m_araddr[63:32] = 32'h0000_5100;
    m_arvalid = 2'b10;
    tick();
    tick();
    tests_run++;
    if ({dbg_state, dbg_grant, m_rvalid} !== {RD, 1'b1, 2'b10}) begin
      tests_failed++; $display("FAIL midrst_in_rd: got %b expected %b", {dbg_state, dbg_grant, m_rvalid}, {RD, 1'b1, 2'b10});
    end
    reset = 1'b1;
    tick();
    tests_run++;
    if ({dbg_state, dbg_ptr, dbg_grant} !== {IDLE, 1'b0, 1'b0} || ctl_outs() !== 15'd0) begin
      tests_failed++; $display("FAIL midrst_cleared: got %b outs %b expected %b 0",
        {dbg_state, dbg_ptr, dbg_grant}, ctl_outs(), {IDLE, 1'b0, 1'b0});
    end
    reset = 1'b0;
    m_rready = 2'b11;
    tick();
    tests_run++;
    if (dbg_state !== IDLE || ctl_outs() !== 15'd0 || rd_cnt[1] !== r1) begin
      tests_failed++; $display("FAIL midrst_after: got %0d outs %b cnt %0d expected %0d 0 %0d",
        dbg_state, ctl_outs(), rd_cnt[1], IDLE, r1);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < N; i++) begin
      rd_cnt[i] = 0;
      wr_cnt[i] = 0;
    end
    test_reset();
    test_single_read();
    test_contention();
    test_write_skew();
    test_rd_wr_same();
    test_backpressure();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
